// File: rtl/gpu_pkg.sv
// Shared constants and FSM encoding for the dot-product issue/collect controller.
package gpu_pkg;

  localparam int MAX_LEN      = 16;
  localparam int ADDR_W       = 4;
  localparam int ACT_W        = 8;
  localparam int LEN_W        = 5;
  localparam int PIPE_LATENCY = 5;
  localparam int RES_W        = 64;
  localparam int RES_LO_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gpu_state_e;

endpackage

// File: rtl/gpu_act_buffer.sv
// 16x8 activation register file: one synchronous write port, one combinational read port.
module gpu_act_buffer
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [ACT_W-1:0]  wr_val,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [ACT_W-1:0]  rd_data
);

  logic [ACT_W-1:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_val;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/gpu_dot_issue_ctrl.sv
// Issues a buffered activation vector into the inference pipeline, one element per cycle,
// and accumulates the returning results into a dot product plus a zero-skip count.
module gpu_dot_issue_ctrl
  import gpu_pkg::*;
#(
  parameter int ACC_W   = 40,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act_write_en,
  input  logic [ADDR_W-1:0] act_write_idx,
  input  logic [ACT_W-1:0]  act_write_val,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              pipe_valid,
  output logic [ADDR_W-1:0] pipe_weight_addr,
  output logic [ACT_W-1:0]  pipe_activation,
  input  logic [RES_W-1:0]  pipe_result,
  input  logic              pipe_result_valid,
  input  logic              pipe_zero_skipped,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic [LEN_W-1:0]  skip_count,
  output logic              err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  gpu_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, ret_cnt_q, len_clamped;
  logic [ADDR_W-1:0] base_q, issue_idx_q, nxt_idx, nxt_base;
  logic [TO_W-1:0]   to_cnt_q;
  logic [ACT_W-1:0]  rd_data;
  logic              start_go, accept, issue_last, finish_to;
  logic              unused_res_hi;

  assign unused_res_hi = ^pipe_result[RES_W-1:RES_LO_W];

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);
  assign len_clamped = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;
  assign accept = busy && pipe_result_valid && (ret_cnt_q < len_q);
  assign issue_last = (state_q == ST_ISSUE) && ({1'b0, issue_idx_q} == len_q - LEN_W'(1));

  // Element index and base for the issue registered at the coming edge.
  assign nxt_idx  = (state_q == ST_ISSUE) ? issue_idx_q + ADDR_W'(1) : '0;
  assign nxt_base = (state_q == ST_IDLE) ? base_addr : base_q;

  gpu_act_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (act_write_en && !busy),
    .wr_idx  (act_write_idx),
    .wr_val  (act_write_val),
    .rd_idx  (nxt_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_go  = 1'b0;
    finish_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = (vec_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ret_cnt_q + LEN_W'(accept) == len_q) begin
          state_d = ST_DONE;
        end else if (!accept && to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          finish_to = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q            <= '0;
      base_q           <= '0;
      issue_idx_q      <= '0;
      ret_cnt_q        <= '0;
      to_cnt_q         <= '0;
      acc_out          <= '0;
      skip_count       <= '0;
      err_timeout      <= 1'b0;
      pipe_valid       <= 1'b0;
      pipe_weight_addr <= '0;
      pipe_activation  <= '0;
    end else begin
      if (start_go) begin
        len_q       <= len_clamped;
        base_q      <= base_addr;
        issue_idx_q <= '0;
        ret_cnt_q   <= '0;
        acc_out     <= '0;
        skip_count  <= '0;
        err_timeout <= 1'b0;
      end else if (accept) begin
        acc_out   <= acc_out + ACC_W'(pipe_result[RES_LO_W-1:0]);
        ret_cnt_q <= ret_cnt_q + LEN_W'(1);
        if (pipe_zero_skipped) skip_count <= skip_count + LEN_W'(1);
      end

      if (state_q == ST_ISSUE && state_d == ST_ISSUE) issue_idx_q <= issue_idx_q + ADDR_W'(1);
      if (finish_to) err_timeout <= 1'b1;

      // Counts cycles since the last issue or returned result.
      case (state_q)
        ST_ISSUE: to_cnt_q <= TO_W'(1);
        ST_DRAIN: to_cnt_q <= accept ? TO_W'(1) : to_cnt_q + TO_W'(1);
        default:  to_cnt_q <= '0;
      endcase

      if (state_d == ST_ISSUE) begin
        pipe_valid       <= 1'b1;
        pipe_weight_addr <= nxt_base + nxt_idx;
        pipe_activation  <= rd_data;
      end else begin
        pipe_valid       <= 1'b0;
        pipe_weight_addr <= '0;
        pipe_activation  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_dot_issue_ctrl.sv
// Directed bench for gpu_dot_issue_ctrl with a behavioural 5-stage multiply pipeline
// (result = weight * activation, zero_skipped when either operand is zero).
module tb_gpu_dot_issue_ctrl;
  import gpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              act_write_en;
  logic [ADDR_W-1:0] act_write_idx;
  logic [ACT_W-1:0]  act_write_val;
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic [ADDR_W-1:0] base_addr;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_weight_addr;
  logic [ACT_W-1:0]  pipe_activation;
  logic [RES_W-1:0]  pipe_result;
  logic              pipe_result_valid;
  logic              pipe_zero_skipped;
  logic              busy;
  logic              done;
  logic [39:0]       acc_out;
  logic [LEN_W-1:0]  skip_count;
  logic              err_timeout;

  always #5 clk = ~clk;

  gpu_dot_issue_ctrl #(.ACC_W(40), .TIMEOUT(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .act_write_en      (act_write_en),
    .act_write_idx     (act_write_idx),
    .act_write_val     (act_write_val),
    .start             (start),
    .vec_len           (vec_len),
    .base_addr         (base_addr),
    .pipe_valid        (pipe_valid),
    .pipe_weight_addr  (pipe_weight_addr),
    .pipe_activation   (pipe_activation),
    .pipe_result       (pipe_result),
    .pipe_result_valid (pipe_result_valid),
    .pipe_zero_skipped (pipe_zero_skipped),
    .busy              (busy),
    .done              (done),
    .acc_out           (acc_out),
    .skip_count        (skip_count),
    .err_timeout       (err_timeout)
  );

  // Pipeline model; pipe_dead turns it into a stub that never returns, inj_valid forces a stray result.
  logic [7:0]       w_mem [MAX_LEN];
  logic             s_v [PIPE_LATENCY];
  logic [RES_W-1:0] s_r [PIPE_LATENCY];
  logic             s_z [PIPE_LATENCY];
  logic             pipe_dead = 1'b0;
  logic             inj_valid = 1'b0;

  always @(posedge clk) begin
    s_v[0] <= pipe_valid && !pipe_dead;
    s_r[0] <= RES_W'(w_mem[pipe_weight_addr]) * RES_W'(pipe_activation);
    s_z[0] <= (w_mem[pipe_weight_addr] == 8'd0) || (pipe_activation == 8'd0);
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      s_v[i] <= s_v[i-1];
      s_r[i] <= s_r[i-1];
      s_z[i] <= s_z[i-1];
    end
  end

  assign pipe_result_valid = s_v[PIPE_LATENCY-1] | inj_valid;
  assign pipe_result       = inj_valid ? 64'd1000 : s_r[PIPE_LATENCY-1];
  assign pipe_zero_skipped = inj_valid ? 1'b1 : s_z[PIPE_LATENCY-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done0 = 0;
  int done_cyc = -1;
  int pv_cnt = 0;
  int pv_rise = 0;
  logic pv_prev = 1'b0;
  logic [ADDR_W-1:0] addr_log[$];
  logic [ADDR_W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pipe_valid) begin
      pv_cnt++;
      if (!pv_prev) pv_rise++;
      addr_log.push_back(pipe_weight_addr);
    end
    pv_prev = pipe_valid;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_act(input int idx, input int val);
    act_write_en  = 1'b1;
    act_write_idx = ADDR_W'(idx);
    act_write_val = ACT_W'(val);
    tick();
    act_write_en  = 1'b0;
  endtask

  task automatic start_run(input int len, input int base);
    start     = 1'b1;
    vec_len   = LEN_W'(len);
    base_addr = ADDR_W'(base);
    t0        = cyc;
    pv_cnt    = 0;
    pv_rise   = 0;
    addr_log.delete();
    done0     = done_cnt;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done_cnt == done0 && n < max) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cnt != done0), 64'd1);
  endtask

  initial begin
    logic [ADDR_W-1:0] got;
    for (int i = 0; i < MAX_LEN; i++) w_mem[i] = 8'd0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      s_v[i] = 1'b0; s_r[i] = '0; s_z[i] = 1'b0;
    end
    rst = 1'b1; act_write_en = 1'b0; act_write_idx = '0; act_write_val = '0;
    start = 1'b0; vec_len = '0; base_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_pv", 64'(pipe_valid), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    rst = 1'b0;
    tick();

    // Basic dot product: 2*1 + 3*2 + 0*3 + 5*4 = 28, one zero-skipped element.
    w_mem[0] = 8'd2; w_mem[1] = 8'd3; w_mem[2] = 8'd0; w_mem[3] = 8'd5;
    for (int i = 0; i < 4; i++) write_act(i, i + 1);
    start_run(4, 0);
    wait_done(40);
    chk("t1_done_cyc", 64'(done_cyc), 64'(t0 + 10));
    chk("t1_acc", 64'(acc_out), 64'd28);
    chk("t1_skip", 64'(skip_count), 64'd1);
    chk("t1_pv_cnt", 64'(pv_cnt), 64'd4);
    chk("t1_pv_rise", 64'(pv_rise), 64'd1);
    chk("t1_err", 64'(err_timeout), 64'd0);
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk("t1_idle_ignore", 64'(acc_out), 64'd28);

    // Address wrap: base 14, weights 1,2,3,4, activations 1 -> 10.
    w_mem[14] = 8'd1; w_mem[15] = 8'd2; w_mem[0] = 8'd3; w_mem[1] = 8'd4;
    for (int i = 0; i < 4; i++) write_act(i, 1);
    exp_q.push_back(4'd14); exp_q.push_back(4'd15); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
    start_run(4, 14);
    wait_done(40);
    chk("t2_addr_n", 64'(addr_log.size()), 64'd4);
    while (exp_q.size() > 0) begin
      got = (addr_log.size() > 0) ? addr_log.pop_front() : 4'hx;
      chk("t2_addr", 64'(got), 64'(exp_q.pop_front()));
    end
    chk("t2_acc", 64'(acc_out), 64'd10);

    // Zero-length vector completes immediately.
    start_run(0, 3);
    wait_done(10);
    chk("t3_done_cyc", 64'(done_cyc), 64'(t0 + 1));
    chk("t3_acc", 64'(acc_out), 64'd0);
    chk("t3_skip", 64'(skip_count), 64'd0);
    chk("t3_pv_cnt", 64'(pv_cnt), 64'd0);

    // Clamped length 20 -> 16; start and writes while busy are ignored.
    for (int i = 0; i < MAX_LEN; i++) w_mem[i] = 8'd2;
    w_mem[3] = 8'd0;
    for (int i = 0; i < MAX_LEN; i++) write_act(i, i + 1);
    start_run(20, 0);
    repeat (3) tick();
    start = 1'b1; vec_len = 5'd2;
    act_write_en = 1'b1; act_write_idx = 4'd0; act_write_val = 8'd99;
    tick();
    start = 1'b0; act_write_en = 1'b0;
    repeat (15) tick();
    start = 1'b1; vec_len = 5'd1;
    tick();
    start = 1'b0;
    wait_done(30);
    chk("t4_done_cyc", 64'(done_cyc), 64'(t0 + 22));
    chk("t4_acc", 64'(acc_out), 64'd264);
    chk("t4_skip", 64'(skip_count), 64'd1);
    chk("t4_pv_cnt", 64'(pv_cnt), 64'd16);
    chk("t4_pv_rise", 64'(pv_rise), 64'd1);
    repeat (4) tick();
    chk("t4_done_once", 64'(done_cnt - done0), 64'd1);
    chk("t4_acc_hold", 64'(acc_out), 64'd264);

    // Dead pipeline: timeout 32 cycles after the last issue (cycle t0+2).
    pipe_dead = 1'b1;
    start_run(2, 0);
    wait_done(80);
    chk("t5_done_cyc", 64'(done_cyc), 64'(t0 + 34));
    chk("t5_err", 64'(err_timeout), 64'd1);
    chk("t5_acc", 64'(acc_out), 64'd0);
    pipe_dead = 1'b0;
    tick();
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);
    start_run(2, 0);
    chk("t5_err_clr", 64'(err_timeout), 64'd0);
    wait_done(40);
    chk("t5b_acc", 64'(acc_out), 64'd6);
    chk("t5b_done_cyc", 64'(done_cyc), 64'(t0 + 8));
    chk("t5b_err", 64'(err_timeout), 64'd0);

    // Reset in DRAIN abandons the run; buffer is cleared.
    start_run(4, 0);
    repeat (5) tick();
    chk("t6_in_drain", 64'({busy, pipe_valid}), 64'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_acc", 64'(acc_out), 64'd0);
    chk("t6_skip", 64'(skip_count), 64'd0);
    chk("t6_pipe", 64'({pipe_valid, pipe_weight_addr, pipe_activation}), 64'd0);
    tick();
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (3) tick();
    chk("t6_late_acc", 64'(acc_out), 64'd0);
    chk("t6_late_skip", 64'(skip_count), 64'd0);
    chk("t6_no_done", 64'(done_cnt - done0), 64'd0);
    start_run(1, 0);
    wait_done(20);
    chk("t6_bufclr_acc", 64'(acc_out), 64'd0);
    chk("t6_bufclr_skip", 64'(skip_count), 64'd1);
    chk("t6_len1_cyc", 64'(done_cyc), 64'(t0 + 7));
    write_act(0, 3); write_act(1, 0); write_act(2, 1); write_act(3, 1);
    start_run(4, 0);
    wait_done(40);
    chk("t6_fresh_acc", 64'(acc_out), 64'd8);
    chk("t6_fresh_skip", 64'(skip_count), 64'd2);
    chk("t6_fresh_cyc", 64'(done_cyc), 64'(t0 + 10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
